trng_sample_ctrl: RTL and testbench
===================================

// Module: trng_sample_ctrl
// PURPOSE
//  Controller and sampler for the 32-bit ring-generator TRNG core. Sequences the core's
//  reset, warm-up and sampling phases, and decimates the core's serial o_pulse output.
//  Packs sampled bits into W-bit words, delivered over a valid/ready interface.
//  Runs a repetition-count health test and locks out on failure. Sits between the
//  ring generator and the host-facing register or stream logic.
// PARAMETERS
//  W         8   output word width in bits (>=2)
//  DECIM     4   clocks per sampled bit (>=1); one i_rg_bit sample every DECIM cycles
//  RST_CYC   2   cycles the core is held in reset on start (>=1)
//  WARMUP    64  cycles run after core reset before the first sample (>=1)
//  RCT_LIMIT 16  consecutive identical samples that declare a fault (>=2)
// PORTS
//  i_clk     in   1  clock, rising edge
//  i_rst_n   in   1  reset, synchronous, active-low
//  i_en      in   1  run request (level); low returns the block to IDLE from any state
//  i_rg_bit  in   1  serial bit from the ring generator (its o_pulse)
//  o_rg_rst  out  1  reset to the ring generator, active-high
//  o_data    out  W  packed random word
//  o_valid   out  1  o_data holds an untaken word
//  i_ready   in   1  consumer accepts o_data when o_valid && i_ready
//  o_busy    out  1  state is SAMPLE
//  o_fault   out  1  health-test failure (state FAULT)
//  o_ovf     out  1  sticky: a completed word was dropped because o_valid was held
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is synchronous and active-low (i_clk, i_rst_n).
//  - Reset (i_rst_n=0 at an edge): state=IDLE, o_rg_rst=1, o_data=0, o_valid=0,
//    o_busy=0, o_fault=0, o_ovf=0, and all counters and the shift register are cleared.
//  State machine
//  - States: IDLE, RESET, WARMUP, SAMPLE, FAULT.
//  - o_rg_rst is decoded from the state register: 1 in IDLE, RESET and FAULT; 0 otherwise.
//  - IDLE->RESET when i_en=1. Entering RESET clears o_ovf, the shift register and bit counters.
//  - RESET lasts RST_CYC cycles, then WARMUP. WARMUP lasts WARMUP cycles, then SAMPLE.
//  - Timing: i_en sampled high at edge k gives RESET in cycles k+1..k+RST_CYC and SAMPLE
//    from cycle k+RST_CYC+WARMUP+1.
//  - i_en=0 in RESET, WARMUP, SAMPLE or FAULT -> IDLE at the next edge.
//    Leaving FAULT this way clears o_fault. Any partial word is discarded and o_valid is
//    cleared. i_en has priority over every other event in the same cycle.
//  Sampling
//  - A decimation counter runs 0..DECIM-1 in SAMPLE and is 0 on SAMPLE entry.
//  - i_rg_bit is sampled when the counter is DECIM-1. The first sample is taken at the
//    DECIM-th SAMPLE cycle.
//  - Packing: sreg <= {sreg[W-2:0], bit}. The first sampled bit lands in o_data[W-1].
//  - On the W-th bit, the completed word moves to o_data, with o_valid=1 from the next
//    cycle, if either:
//      - o_valid=0, or
//      - o_valid && i_ready in the same cycle (back-to-back handoff).
//    Otherwise the word is dropped, o_data is kept, and o_ovf is set.
//  - Handshake: a transfer occurs when o_valid && i_ready. o_data is stable while
//    o_valid && !i_ready. o_valid falls after a transfer unless a new word loads in the
//    same cycle.
//  Health test (repetition count)
//  - Each sample is compared with the previous one. The run count resets to 1 on a
//    change and to 1 on the first sample after SAMPLE entry.
//  - Run count reaching RCT_LIMIT -> FAULT at the next edge. In that cycle the partial
//    word and any untaken o_valid word are discarded. o_valid=0 and o_fault=1 remain
//    until IDLE.
//  - If a word completes on the same sample that trips the test, the fault wins and the
//    word is not delivered.
//  - A counter wrap does not occur: the run count saturates at RCT_LIMIT.
// TESTING
//  1 Reset: i_rst_n=0 for 2 cycles, i_en=0 -> o_rg_rst=1, o_valid=0, o_fault=0,
//    o_ovf=0, o_data=0.
//  2 Start timing (defaults): i_en=1 at edge 0 -> o_rg_rst=1 through cycle 2,
//    0 from cycle 3; o_busy=1 from cycle 67.
//  3 Alternating samples 1,0,1,0,... with i_ready=1 -> o_data=8'hAA, o_valid pulses
//    one cycle per word. Words repeat every 32 cycles; the first o_valid is in cycle 99.
//  4 Back-pressure: i_ready=0 with pattern AA then 55 -> o_data stays 8'hAA,
//    o_valid=1, o_ovf=1 after the second word. i_ready=1 for one cycle -> o_valid=0.
//  5 Stuck core: i_rg_bit=1 constant, i_ready=0 -> first word 8'hFF valid. On the 16th
//    sample: o_fault=1, o_valid=0, o_rg_rst=1. i_en=0 -> IDLE, o_fault=0.
//  6 Abort: drop i_en after 5 samples in SAMPLE -> IDLE at the next edge, o_rg_rst=1,
//    o_valid=0. Re-enable -> the first word contains only new samples.

Source files
------------

// File: rtl/trng_sample_ctrl.sv
// Ring-generator TRNG controller: sequences core reset/warm-up, decimates and packs
// i_rg_bit into W-bit words on a valid/ready port, and runs a repetition-count health test.
module trng_sample_ctrl #(
  parameter int W         = 8,
  parameter int DECIM     = 4,
  parameter int RST_CYC   = 2,
  parameter int WARMUP    = 64,
  parameter int RCT_LIMIT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_rg_bit,
  output logic         o_rg_rst,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_busy,
  output logic         o_fault,
  output logic         o_ovf
);

  localparam int CYC_MAX = (RST_CYC > WARMUP) ? RST_CYC : WARMUP;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int DEC_W   = $clog2(DECIM + 1);
  localparam int BIT_W   = $clog2(W + 1);
  localparam int RUN_W   = $clog2(RCT_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WARMUP,
    S_SAMPLE,
    S_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CYC_W-1:0]   r_cyc;
  logic [DEC_W-1:0]   r_dec;
  logic [BIT_W-1:0]   r_bits;
  logic [RUN_W-1:0]   r_run;
  logic               r_prev;
  logic [W-1:0]       r_sreg;
  logic [W-1:0]       r_data;
  logic               r_valid;
  logic               r_ovf;

  logic               w_sample;
  logic [RUN_W-1:0]   w_run_next;
  logic               w_trip;
  logic [W-1:0]       w_word;
  logic               w_word_done;
  logic               w_xfer;

  assign w_sample    = (r_state == S_SAMPLE) && (r_dec == DEC_W'(DECIM - 1));
  // r_run == 0 marks "no previous sample since SAMPLE entry".
  assign w_run_next  = ((r_run == '0) || (i_rg_bit != r_prev)) ? RUN_W'(1) :
                       (r_run == RUN_W'(RCT_LIMIT))             ? r_run :
                                                                  r_run + RUN_W'(1);
  assign w_trip      = w_sample && (w_run_next == RUN_W'(RCT_LIMIT));
  assign w_word      = {r_sreg[W-2:0], i_rg_bit};
  assign w_word_done = w_sample && (r_bits == BIT_W'(W - 1));
  assign w_xfer      = r_valid && i_ready;

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_en) w_next = S_RESET;
      S_RESET:  if (r_cyc == CYC_W'(RST_CYC - 1)) w_next = S_WARMUP;
      S_WARMUP: if (r_cyc == CYC_W'(WARMUP - 1)) w_next = S_SAMPLE;
      S_SAMPLE: if (w_trip) w_next = S_FAULT;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
    if (!i_en) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cyc   <= '0;
      r_dec   <= '0;
      r_bits  <= '0;
      r_run   <= '0;
      r_prev  <= 1'b0;
      r_sreg  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_cyc <= '0;
      else if ((r_state == S_RESET) || (r_state == S_WARMUP))
        r_cyc <= r_cyc + CYC_W'(1);

      if ((r_state == S_SAMPLE) && (w_next == S_SAMPLE))
        r_dec <= (r_dec == DEC_W'(DECIM - 1)) ? '0 : r_dec + DEC_W'(1);
      else
        r_dec <= '0;

      if ((w_next == S_IDLE) || (w_next == S_FAULT)) begin
        r_valid <= 1'b0;
        r_sreg  <= '0;
        r_bits  <= '0;
        r_run   <= '0;
      end else if ((r_state == S_IDLE) && (w_next == S_RESET)) begin
        r_ovf  <= 1'b0;
        r_sreg <= '0;
        r_bits <= '0;
        r_run  <= '0;
      end else if (r_state == S_SAMPLE) begin
        if (w_xfer) r_valid <= 1'b0;
        if (w_sample) begin
          r_prev <= i_rg_bit;
          r_run  <= w_run_next;
          if (w_word_done) begin
            r_bits <= '0;
            r_sreg <= '0;
            // Load only when the output slot is empty or being emptied this cycle.
            if (!r_valid || i_ready) begin
              r_data  <= w_word;
              r_valid <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_sreg <= w_word;
            r_bits <= r_bits + BIT_W'(1);
          end
        end
      end
    end
  end

  assign o_rg_rst = (r_state == S_IDLE) || (r_state == S_RESET) || (r_state == S_FAULT);
  assign o_busy   = (r_state == S_SAMPLE);
  assign o_fault  = (r_state == S_FAULT);
  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl (default parameters). Cycle n is the clock period
// that ends with edge n; edge 0 is the edge that samples i_en high.
module tb_trng_sample_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n, i_en, i_rg_bit, i_ready;
  logic       o_rg_rst, o_valid, o_busy, o_fault, o_ovf;
  logic [7:0] o_data;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic bitq[$];

  always #5 clk = ~clk;

  trng_sample_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_rg_bit(i_rg_bit),
    .o_rg_rst(o_rg_rst),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_fault (o_fault),
    .o_ovf   (o_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next falling edge; a new sample bit is presented at the start of
  // every 4-cycle decimation window, beginning with the first SAMPLE cycle (67).
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc >= 67 && ((cyc - 67) % 4) == 0 && bitq.size() > 0)
      i_rg_bit = bitq.pop_front();
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_rg_bit = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rg_rst", o_rg_rst, 1);
    check("rst_valid",  o_valid,  0);
    check("rst_fault",  o_fault,  0);
    check("rst_ovf",    o_ovf,    0);
    check("rst_data",   o_data,   8'h00);
    check("rst_busy",   o_busy,   0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("idle_rg_rst", o_rg_rst, 1);

    // Run 1: alternating bits AA AA AA 55, ready high then back-pressure.
    push_byte(8'hAA); push_byte(8'hAA); push_byte(8'hAA); push_byte(8'h55);
    i_en = 1'b1; cyc = 0;
    tick_to(2);   check("start_rg_rst_c2", o_rg_rst, 1);
    tick_to(3);   check("start_rg_rst_c3", o_rg_rst, 0);
    tick_to(66);  check("busy_c66", o_busy, 0);
    tick_to(67);  check("busy_c67", o_busy, 1);
    tick_to(98);  check("w1_valid_c98", o_valid, 0);
    tick_to(99);  check("w1_valid_c99", o_valid, 1);
                  check("w1_data", o_data, 8'hAA);
    tick_to(100); check("w1_valid_c100", o_valid, 0);
    tick_to(131); check("w2_valid", o_valid, 1);
                  check("w2_data", o_data, 8'hAA);
    tick_to(132); check("w2_valid_drop", o_valid, 0);
    i_ready = 1'b0;
    tick_to(163); check("bp_w3_valid", o_valid, 1);
                  check("bp_w3_data", o_data, 8'hAA);
                  check("bp_w3_ovf", o_ovf, 0);
    tick_to(194); check("bp_hold_valid", o_valid, 1);
                  check("bp_ovf_c194", o_ovf, 0);
    tick_to(195); check("bp_w4_data_kept", o_data, 8'hAA);
                  check("bp_w4_valid", o_valid, 1);
                  check("bp_w4_ovf", o_ovf, 1);
    tick_to(196); i_ready = 1'b1;
    tick_to(197); check("bp_taken_valid", o_valid, 0);
                  check("bp_ovf_sticky", o_ovf, 1);
    i_en = 1'b0;
    tick_to(198); check("r1_off_rg_rst", o_rg_rst, 1);
                  check("r1_off_busy", o_busy, 0);

    // Run 2: stuck-at-1 core with ready low.
    i_en = 1'b1; i_ready = 1'b0; i_rg_bit = 1'b1; cyc = 0;
    tick_to(1);   check("r2_ovf_cleared", o_ovf, 0);
    tick_to(99);  check("stuck_w1_valid", o_valid, 1);
                  check("stuck_w1_data", o_data, 8'hFF);
    tick_to(130); check("stuck_15_fault", o_fault, 0);
                  check("stuck_15_valid", o_valid, 1);
    tick_to(131); check("stuck_16_fault", o_fault, 1);
                  check("stuck_16_valid", o_valid, 0);
                  check("stuck_16_rg_rst", o_rg_rst, 1);
                  check("stuck_16_ovf", o_ovf, 0);
                  check("stuck_16_busy", o_busy, 0);
    tick_to(132); i_en = 1'b0;
    tick_to(133); check("fault_clear", o_fault, 0);
                  check("fault_idle_rg_rst", o_rg_rst, 1);

    // Run 3: abort after five samples.
    i_en = 1'b1; i_ready = 1'b1; cyc = 0;
    for (int i = 0; i < 5; i++) bitq.push_back(1'b1);
    tick_to(87);  check("abort_busy_pre", o_busy, 1);
    i_en = 1'b0;
    tick_to(88);  check("abort_rg_rst", o_rg_rst, 1);
                  check("abort_busy", o_busy, 0);
                  check("abort_valid", o_valid, 0);

    // Run 4: first word must hold only fresh samples.
    i_en = 1'b1; cyc = 0;
    push_byte(8'h4D);
    tick_to(98);  check("r4_valid_c98", o_valid, 0);
    tick_to(99);  check("r4_valid_c99", o_valid, 1);
                  check("r4_data", o_data, 8'h4D);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
